// File: rtl/geri_yaz_if.sv
// Bus between the memory stage / L1 read port and the write-back stage.
// master = upstream/test side, slave = geri_yaz.
interface geri_yaz_if #(
    parameter int VERI_BIT   = 32,
    parameter int YAZMAC_BIT = 5
);
    logic                  uop_gecerli_i;
    logic                  uop_yaz_i;
    logic                  uop_yukle_i;
    logic [2:0]            uop_yukle_tur_i;
    logic [1:0]            uop_adres_lsb_i;
    logic [YAZMAC_BIT-1:0] uop_rd_i;
    logic [VERI_BIT-1:0]   uop_sonuc_i;

    logic [VERI_BIT-1:0]   l1v_veri_i;
    logic                  l1v_veri_gecerli_i;
    logic                  l1v_veri_hazir_o;

    logic                  duraklat_o;
    logic                  yazmac_yaz_o;
    logic [YAZMAC_BIT-1:0] yazmac_adres_o;
    logic [VERI_BIT-1:0]   yazmac_veri_o;

    modport slave (
        input  uop_gecerli_i, uop_yaz_i, uop_yukle_i, uop_yukle_tur_i,
               uop_adres_lsb_i, uop_rd_i, uop_sonuc_i,
               l1v_veri_i, l1v_veri_gecerli_i,
        output l1v_veri_hazir_o, duraklat_o,
               yazmac_yaz_o, yazmac_adres_o, yazmac_veri_o
    );

    modport master (
        output uop_gecerli_i, uop_yaz_i, uop_yukle_i, uop_yukle_tur_i,
               uop_adres_lsb_i, uop_rd_i, uop_sonuc_i,
               l1v_veri_i, l1v_veri_gecerli_i,
        input  l1v_veri_hazir_o, duraklat_o,
               yazmac_yaz_o, yazmac_adres_o, yazmac_veri_o
    );
endinterface

// File: rtl/geri_yaz.sv
// Write-back stage: commits ALU results and extracted/extended L1 load data to the register file.
// Latency: non-load write 1 cycle after accept; load write 1 cycle after the L1 data handshake.
// Backpressure: BEKLE holds upstream via duraklat_o and accepts L1 data; optional retire counter under GERI_YAZ_EMEKLI_SAYAC_EN.
module geri_yaz #(
    parameter int VERI_BIT   = 32,
    parameter int YAZMAC_BIT = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef GERI_YAZ_EMEKLI_SAYAC_EN
    output logic [63:0] emekli_sayac_o,
`endif
    geri_yaz_if.slave   bus
);

    typedef enum logic [0:0] {
        BOSTA = 1'b0,
        BEKLE = 1'b1
    } durum_t;

    durum_t                durum_q, durum_d;
    logic [YAZMAC_BIT-1:0] rd_q, rd_d;
    logic                  yaz_q, yaz_d;
    logic [2:0]            tur_q, tur_d;
    logic [1:0]            lsb_q, lsb_d;

    logic                  yyaz_q, yyaz_d;
    logic [YAZMAC_BIT-1:0] adres_q, adres_d;
    logic [VERI_BIT-1:0]   veri_q, veri_d;

    // Load data extraction; undefined funct3 values fall through to the full word.
    function automatic logic [VERI_BIT-1:0] cikar(
        input logic [2:0]          tur,
        input logic [1:0]          lsb,
        input logic [VERI_BIT-1:0] w
    );
        logic [7:0]          b;
        logic [15:0]         h;
        logic [VERI_BIT-1:0] r;
        case (lsb)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lsb[1] ? w[31:16] : w[15:0];
        case (tur)
            3'b000:  r = {{(VERI_BIT-8){b[7]}}, b};
            3'b001:  r = {{(VERI_BIT-16){h[15]}}, h};
            3'b100:  r = {{(VERI_BIT-8){1'b0}}, b};
            3'b101:  r = {{(VERI_BIT-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        durum_d = durum_q;
        rd_d    = rd_q;
        yaz_d   = yaz_q;
        tur_d   = tur_q;
        lsb_d   = lsb_q;
        yyaz_d  = 1'b0;
        adres_d = adres_q;
        veri_d  = veri_q;

        case (durum_q)
            BOSTA: begin
                if (bus.uop_gecerli_i) begin
                    if (bus.uop_yukle_i) begin
                        rd_d    = bus.uop_rd_i;
                        yaz_d   = bus.uop_yaz_i;
                        tur_d   = bus.uop_yukle_tur_i;
                        lsb_d   = bus.uop_adres_lsb_i;
                        durum_d = BEKLE;
                    end else if (bus.uop_yaz_i && (bus.uop_rd_i != '0)) begin
                        yyaz_d  = 1'b1;
                        adres_d = bus.uop_rd_i;
                        veri_d  = bus.uop_sonuc_i;
                    end
                end
            end
            BEKLE: begin
                if (bus.l1v_veri_gecerli_i) begin
                    durum_d = BOSTA;
                    if (yaz_q && (rd_q != '0)) begin
                        yyaz_d  = 1'b1;
                        adres_d = rd_q;
                        veri_d  = cikar(tur_q, lsb_q, bus.l1v_veri_i);
                    end
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
            rd_q    <= '0;
            yaz_q   <= 1'b0;
            tur_q   <= '0;
            lsb_q   <= '0;
            yyaz_q  <= 1'b0;
            adres_q <= '0;
            veri_q  <= '0;
        end else begin
            durum_q <= durum_d;
            rd_q    <= rd_d;
            yaz_q   <= yaz_d;
            tur_q   <= tur_d;
            lsb_q   <= lsb_d;
            yyaz_q  <= yyaz_d;
            adres_q <= adres_d;
            veri_q  <= veri_d;
        end
    end

    assign bus.l1v_veri_hazir_o = (durum_q == BEKLE);
    assign bus.duraklat_o       = (durum_q == BEKLE);
    assign bus.yazmac_yaz_o     = yyaz_q;
    assign bus.yazmac_adres_o   = adres_q;
    assign bus.yazmac_veri_o    = veri_q;

`ifdef GERI_YAZ_EMEKLI_SAYAC_EN
    logic [63:0] sayac_q, sayac_d;
    logic        emekli;

    // rd=0 and yaz=0 micro-ops still retire and are counted.
    assign emekli = ((durum_q == BOSTA) && bus.uop_gecerli_i && !bus.uop_yukle_i) ||
                    ((durum_q == BEKLE) && bus.l1v_veri_gecerli_i);

    always_comb begin
        sayac_d = sayac_q;
        if (emekli) sayac_d = sayac_q + 64'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) sayac_q <= '0;
        else       sayac_q <= sayac_d;
    end

    assign emekli_sayac_o = sayac_q;
`endif

endmodule

// File: doc/geri_yaz.md
# geri_yaz

Write-back stage of the in-order core, directly downstream of the memory stage. Takes the decoded micro-op fields the memory stage hands over and commits the result to the register file. ALU results pass straight through. Loads wait for L1 data, which is byte/halfword-selected and sign/zero-extended before commit. While a load is pending the stage holds the upstream pipeline and drives the L1 read-data handshake.

## Interface
- `VERI_BIT`, 32: data/register width (only 32 supported).
- `YAZMAC_BIT`, 5: register-address width.
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `uop_gecerli_i` in 1: micro-op valid.
- `uop_yaz_i` in 1: micro-op writes `rd`.
- `uop_yukle_i` in 1: micro-op is a load.
- `uop_yukle_tur_i` in 3: load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `uop_adres_lsb_i` in 2: load address bits [1:0].
- `uop_rd_i` in `YAZMAC_BIT`: destination register.
- `uop_sonuc_i` in `VERI_BIT`: ALU/pass-through result.
- `l1v_veri_i` in `VERI_BIT`: word-aligned L1 read data.
- `l1v_veri_gecerli_i` in 1: L1 data valid.
- `l1v_veri_hazir_o` out 1: stage ready for L1 data.
- `duraklat_o` out 1: stall request to upstream.
- `yazmac_yaz_o` out 1: register-file write enable (also the forwarding valid).
- `yazmac_adres_o` out `YAZMAC_BIT`: write address.
- `yazmac_veri_o` out `VERI_BIT`: write data.
- `emekli_sayac_o` out 64: retired micro-op count (only with `GERI_YAZ_EMEKLI_SAYAC_EN`).

## Operation
- FSM states: BOSTA (accepting) and BEKLE (load pending). Reset state is BOSTA.
- **BOSTA, valid, non-load:**
  - Next cycle: `yazmac_yaz_o` = `uop_yaz_i && rd!=0`, `yazmac_adres_o` = `rd`, `yazmac_veri_o` = `uop_sonuc_i`.
  - Stay in BOSTA.
- **BOSTA, valid, load:**
  - Latch `rd`, `yaz`, `tur` and `lsb`, then go to BEKLE.
  - No write in the next cycle.
- **BOSTA, not valid:** `yazmac_yaz_o` = 0 next cycle.
- **BEKLE:**
  - `l1v_veri_hazir_o` = 1 and `duraklat_o` = 1; both are Moore outputs of the state.
  - Upstream holds its `uop_*` inputs stable and none is accepted.
- **BEKLE with `l1v_veri_gecerli_i` = 1 (handshake):**
  - Next cycle: write the extracted data to latched `rd`, gated by latched `yaz && rd!=0`.
  - Return to BOSTA.
- **Extraction:**
  - Byte = `l1v_veri_i[8*lsb +: 8]`.
  - Halfword = `l1v_veri_i[16*lsb[1] +: 16]`; `lsb[0]` is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Undefined funct3 values are treated as LW.
- `rd`=0 never asserts `yazmac_yaz_o`, but the micro-op still retires.
- `yazmac_adres_o`/`yazmac_veri_o` hold their last value when `yazmac_yaz_o`=0.
- L1 data presented in BOSTA is ignored, since `l1v_veri_hazir_o`=0 there.

## Timing
- Reset values: state BOSTA, `l1v_veri_hazir_o`=0, `duraklat_o`=0, `yazmac_yaz_o`=0, `yazmac_adres_o`=0, `yazmac_veri_o`=0, `emekli_sayac_o`=0.
- Non-load latency: accept at cycle t, write visible in cycle t+1.
- Load latency:
  - Accept at t; BEKLE from t+1.
  - Handshake at t+k (k≥1); write visible at t+k+1, which is also the first BOSTA cycle.
  - The next micro-op is accepted at t+k+1.
- Data arriving in the first BEKLE cycle (k=1) is legal and consumed.
- Back-to-back loads: the second load is accepted in the write cycle of the first, so BOSTA lasts exactly one cycle between them.
- Reset during BEKLE: the pending load is discarded. Next cycle is BOSTA with `l1v_veri_hazir_o`=0, `duraklat_o`=0 and no write.
- All outputs are registered or decoded from state; there is no combinational input-to-output path.

## Configuration
- `GERI_YAZ_EMEKLI_SAYAC_EN` defined:
  - A 64-bit counter drives `emekli_sayac_o`.
  - It increments by 1 on each valid non-load accepted in BOSTA and on each load data handshake, including `rd`=0 and `yaz`=0 micro-ops.
  - It wraps from 2^64-1 to 0 and resets to 0.
- `GERI_YAZ_EMEKLI_SAYAC_EN` undefined: the port and counter are absent.

## Test plan
- ADD result: valid non-load, `rd`=5, `sonuc`=0x1234_5678 → next cycle `yaz`=1, `adres`=5, `veri`=0x1234_5678; `duraklat_o` stays 0.
- Signed byte load: LB, `lsb`=2, `rd`=7, L1 data 0x00_80_00_00 after 3 BEKLE cycles.
  - `duraklat_o`/`l1v_veri_hazir_o`=1 for 3 cycles.
  - Write `rd`=7 with 0xFFFF_FF80 one cycle after the handshake.
- Halfword loads, L1 data 0x8001_7FFF:
  - LHU, `lsb`=2 → 0x0000_8001.
  - LH, `lsb`=0 → 0x0000_7FFF.
  - LH, `lsb`=2 → 0xFFFF_8001.
- `rd`=0 micro-ops: non-load and load each produce no write; with the macro defined, the counter advances by 2.
- Reset mid-load: assert `rst_i` in BEKLE, then present `l1v_veri_gecerli_i`=1 → no write, `l1v_veri_hazir_o`=0, state BOSTA.
- Back-to-back LW then ADD, data valid at k=1 → load write at t+2, ADD accepted at t+2, ADD write at t+3.
